spawn_scheduler: RTL and testbench

Shared spawn arbiter between the level logic and the object pools (trees, birds, pickup). Level logic posts spawn requests as counts. The block paces them to at most one deploy per GAP_FRAMES frames and shares that slot between the three classes round-robin. For each grant it picks the lowest free object slot and emits a one-cycle one-hot deploy pulse. It replaces ad-hoc per-class spawn timers in the game controller.

---
 rtl/spawn_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_spawn_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces tree/bird/pickup spawn requests into one-hot deploy pulses, round-robin between classes.
// Latency: deploy pulse is registered, high for the single cycle after the edge that samples startOfFrame.
// Backpressure: none; requests accumulate in saturating pending counters, further adds drop at saturation.
module spawn_scheduler #(
  parameter int N_TREE     = 16,
  parameter int N_BIRD     = 4,
  parameter int GAP_FRAMES = 8,
  parameter int PEND_W     = 5
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              flush,
  input  logic              add_tree_valid,
  input  logic [3:0]        add_tree_cnt,
  input  logic              add_bird_valid,
  input  logic [2:0]        add_bird_cnt,
  input  logic              req_pickup,
  input  logic [N_TREE-1:0] tree_alive,
  input  logic [N_BIRD-1:0] bird_alive,
  input  logic              pickup_alive,
  output logic [N_TREE-1:0] deploy_tree,
  output logic [N_BIRD-1:0] deploy_bird,
  output logic              deploy_pickup,
  output logic [PEND_W-1:0] pending_tree,
  output logic [PEND_W-1:0] pending_bird,
  output logic              idle
);

  localparam int                GAP_W    = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_FRAMES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [1:0]        C_TREE   = 2'd0;
  localparam logic [1:0]        C_BIRD   = 2'd1;
  localparam logic [1:0]        C_PICK   = 2'd2;

  logic [PEND_W-1:0] r_pend_t, r_pend_b;
  logic              r_pend_p;
  logic [GAP_W-1:0]  r_gap;
  logic [1:0]        r_rr;
  logic [N_TREE-1:0] r_rsv_t, r_dep_t;
  logic [N_BIRD-1:0] r_rsv_b, r_dep_b;
  logic              r_rsv_p, r_dep_p;
  logic [1:0]        r_age_t, r_age_b, r_age_p;

  logic [N_TREE-1:0] w_free_t, w_pick_t;
  logic [N_BIRD-1:0] w_free_b, w_pick_b;
  logic              w_free_p;
  logic [2:0]        w_elig;
  logic              w_gnt_vld;
  logic [1:0]        w_gnt_cls;
  logic              w_gnt_t, w_gnt_b, w_gnt_p;
  logic              w_sof;
  logic              w_tmo_t, w_tmo_b, w_tmo_p;

  // Class index k positions after base in TREE->BIRD->PICKUP order.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= 3) s = s - 3;
    return s[1:0];
  endfunction

  // Saturating add of the request count, then the grant decrement.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur, input logic add,
                                                  input logic [PEND_W-1:0] cnt, input logic dec);
    logic [PEND_W:0]   sum;
    logic [PEND_W-1:0] sat;
    sum = {1'b0, cur} + (add ? {1'b0, cnt} : '0);
    sat = sum[PEND_W] ? PEND_MAX : sum[PEND_W-1:0];
    return sat - PEND_W'(dec);
  endfunction

  // A slot is free when its object is dead and no deploy is still in flight to it.
  assign w_free_t = ~tree_alive & ~r_rsv_t;
  assign w_free_b = ~bird_alive & ~r_rsv_b;
  assign w_free_p = ~pickup_alive & ~r_rsv_p;
  assign w_pick_t = w_free_t & (~w_free_t + N_TREE'(1));
  assign w_pick_b = w_free_b & (~w_free_b + N_BIRD'(1));

  assign w_elig = {w_free_p & r_pend_p,
                   (|w_free_b) & (r_pend_b != '0),
                   (|w_free_t) & (r_pend_t != '0)};

  assign w_sof = startOfFrame & ~flush;

  // Pick the first eligible class at or after the round-robin pointer; only on an open frame slot.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_cls = C_TREE;
    for (int k = 2; k >= 0; k--) begin
      if (w_elig[rr_add(r_rr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_cls = rr_add(r_rr, k);
      end
    end
    if (!w_sof || (r_gap != '0)) w_gnt_vld = 1'b0;
  end

  assign w_gnt_t = w_gnt_vld & (w_gnt_cls == C_TREE);
  assign w_gnt_b = w_gnt_vld & (w_gnt_cls == C_BIRD);
  assign w_gnt_p = w_gnt_vld & (w_gnt_cls == C_PICK);

  // A class whose reservation timer expires this frame drops its whole reserved mask.
  assign w_tmo_t = w_sof & (r_age_t == 2'd1);
  assign w_tmo_b = w_sof & (r_age_b == 2'd1);
  assign w_tmo_p = w_sof & (r_age_p == 2'd1);

  // Pending counters, frame gap and round-robin pointer; flush overrides adds and grants.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pend_t <= '0;
      r_pend_b <= '0;
      r_pend_p <= 1'b0;
      r_gap    <= '0;
      r_rr     <= C_TREE;
    end else if (flush) begin
      r_pend_t <= '0;
      r_pend_b <= '0;
      r_pend_p <= 1'b0;
      r_gap    <= '0;
      r_rr     <= C_TREE;
    end else begin
      r_pend_t <= pend_next(r_pend_t, add_tree_valid, PEND_W'(add_tree_cnt), w_gnt_t);
      r_pend_b <= pend_next(r_pend_b, add_bird_valid, PEND_W'(add_bird_cnt), w_gnt_b);
      // A new pickup request arriving on the grant cycle is kept, not lost.
      r_pend_p <= req_pickup | (r_pend_p & ~w_gnt_p);
      if (startOfFrame) begin
        if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
        else if (w_gnt_vld) r_gap <= GAP_LOAD;
      end
      if (w_gnt_vld) r_rr <= (w_gnt_cls == C_PICK) ? C_TREE : w_gnt_cls + 2'd1;
    end
  end

  // Reservations: set on deploy, released when the object reports alive or when the class timer runs out.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rsv_t <= '0;
      r_rsv_b <= '0;
      r_rsv_p <= 1'b0;
      r_age_t <= 2'd0;
      r_age_b <= 2'd0;
      r_age_p <= 2'd0;
    end else if (flush) begin
      r_rsv_t <= '0;
      r_rsv_b <= '0;
      r_rsv_p <= 1'b0;
      r_age_t <= 2'd0;
      r_age_b <= 2'd0;
      r_age_p <= 2'd0;
    end else begin
      r_rsv_t <= (w_tmo_t ? '0 : (r_rsv_t & ~tree_alive)) | (w_gnt_t ? w_pick_t : '0);
      r_rsv_b <= (w_tmo_b ? '0 : (r_rsv_b & ~bird_alive)) | (w_gnt_b ? w_pick_b : '0);
      r_rsv_p <= (w_tmo_p ? 1'b0 : (r_rsv_p & ~pickup_alive)) | w_gnt_p;
      if (w_gnt_t) r_age_t <= 2'd3;
      else if (startOfFrame && r_age_t != 2'd0) r_age_t <= r_age_t - 2'd1;
      if (w_gnt_b) r_age_b <= 2'd3;
      else if (startOfFrame && r_age_b != 2'd0) r_age_b <= r_age_b - 2'd1;
      if (w_gnt_p) r_age_p <= 2'd3;
      else if (startOfFrame && r_age_p != 2'd0) r_age_p <= r_age_p - 2'd1;
    end
  end

  // Registered one-cycle deploy pulses; grants are already suppressed during flush.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_dep_t <= '0;
      r_dep_b <= '0;
      r_dep_p <= 1'b0;
    end else begin
      r_dep_t <= w_gnt_t ? w_pick_t : '0;
      r_dep_b <= w_gnt_b ? w_pick_b : '0;
      r_dep_p <= w_gnt_p;
    end
  end

  assign deploy_tree   = r_dep_t;
  assign deploy_bird   = r_dep_b;
  assign deploy_pickup = r_dep_p;
  assign pending_tree  = r_pend_t;
  assign pending_bird  = r_pend_b;
  assign idle          = (r_pend_t == '0) && (r_pend_b == '0) && !r_pend_p && (r_gap == '0);

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed scenarios plus random traffic against a slot/queue-level reference model.
// Latency: outputs sampled 1 ns after each rising edge and compared with the model's expectation for that edge.
// Backpressure: not applicable; the bench drives inputs freely every cycle.
module tb_spawn_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN, startOfFrame, flush;
  logic        add_tree_valid, add_bird_valid, req_pickup, pickup_alive;
  logic [3:0]  add_tree_cnt;
  logic [2:0]  add_bird_cnt;
  logic [15:0] tree_alive;
  logic [3:0]  bird_alive;
  logic [15:0] deploy_tree;
  logic [3:0]  deploy_bird;
  logic        deploy_pickup;
  logic [4:0]  pending_tree, pending_bird;
  logic        idle;

  spawn_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .flush(flush),
    .add_tree_valid(add_tree_valid), .add_tree_cnt(add_tree_cnt),
    .add_bird_valid(add_bird_valid), .add_bird_cnt(add_bird_cnt),
    .req_pickup(req_pickup), .tree_alive(tree_alive), .bird_alive(bird_alive),
    .pickup_alive(pickup_alive), .deploy_tree(deploy_tree), .deploy_bird(deploy_bird),
    .deploy_pickup(deploy_pickup), .pending_tree(pending_tree), .pending_bird(pending_bird),
    .idle(idle)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit auto_alive = 0;

  // Reference model: class 0 = tree, 1 = bird, 2 = pickup.
  int          m_pend[2];
  bit          m_pp;
  int          m_gap;
  int          m_rr;
  bit          m_rsv_t[16];
  bit          m_rsv_b[4];
  bit          m_rsv_p;
  int          m_age[3];
  logic [15:0] e_dt;
  logic [3:0]  e_db;
  logic        e_dp;

  task automatic model_clear();
    m_pend[0] = 0; m_pend[1] = 0; m_pp = 0; m_gap = 0; m_rr = 0; m_rsv_p = 0;
    for (int i = 0; i < 16; i++) m_rsv_t[i] = 0;
    for (int i = 0; i < 4; i++) m_rsv_b[i] = 0;
    for (int c = 0; c < 3; c++) m_age[c] = 0;
    e_dt = '0; e_db = '0; e_dp = 1'b0;
  endtask

  function automatic int first_free_t();
    for (int i = 0; i < 16; i++) if (!tree_alive[i] && !m_rsv_t[i]) return i;
    return -1;
  endfunction

  function automatic int first_free_b();
    for (int i = 0; i < 4; i++) if (!bird_alive[i] && !m_rsv_b[i]) return i;
    return -1;
  endfunction

  function automatic int sat31(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int ft, fb, g, c;
    bit el[3];
    if (flush) begin
      model_clear();
      return;
    end
    ft = first_free_t();
    fb = first_free_b();
    el[0] = (m_pend[0] > 0) && (ft >= 0);
    el[1] = (m_pend[1] > 0) && (fb >= 0);
    el[2] = m_pp && !pickup_alive && !m_rsv_p;
    g = -1;
    if (startOfFrame && m_gap == 0)
      for (int k = 0; k < 3; k++) begin
        c = (m_rr + k) % 3;
        if (el[c] && g < 0) g = c;
      end
    e_dt = '0; e_db = '0; e_dp = 1'b0;
    if (g == 0) e_dt[ft] = 1'b1;
    if (g == 1) e_db[fb] = 1'b1;
    if (g == 2) e_dp = 1'b1;
    if (add_tree_valid) m_pend[0] = sat31(m_pend[0] + int'(add_tree_cnt));
    if (add_bird_valid) m_pend[1] = sat31(m_pend[1] + int'(add_bird_cnt));
    if (g == 0) m_pend[0]--;
    if (g == 1) m_pend[1]--;
    if (g == 2) m_pp = 0;
    if (req_pickup) m_pp = 1;
    for (int i = 0; i < 16; i++) if (tree_alive[i]) m_rsv_t[i] = 0;
    for (int i = 0; i < 4; i++) if (bird_alive[i]) m_rsv_b[i] = 0;
    if (pickup_alive) m_rsv_p = 0;
    if (startOfFrame)
      for (int k = 0; k < 3; k++)
        if (m_age[k] > 0) begin
          m_age[k]--;
          if (m_age[k] == 0) begin
            if (k == 0) for (int i = 0; i < 16; i++) m_rsv_t[i] = 0;
            if (k == 1) for (int i = 0; i < 4; i++) m_rsv_b[i] = 0;
            if (k == 2) m_rsv_p = 0;
          end
        end
    if (g == 0) m_rsv_t[ft] = 1;
    if (g == 1) m_rsv_b[fb] = 1;
    if (g == 2) m_rsv_p = 1;
    if (g >= 0) m_age[g] = 3;
    if (startOfFrame) begin
      if (m_gap > 0) m_gap--;
      else if (g >= 0) m_gap = 7;
    end
    if (g >= 0) m_rr = (g + 1) % 3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic m_idle;
    m_idle = (m_pend[0] == 0) && (m_pend[1] == 0) && !m_pp && (m_gap == 0);
    chk("deploy_tree", 32'(deploy_tree), 32'(e_dt));
    chk("deploy_bird", 32'(deploy_bird), 32'(e_db));
    chk("deploy_pickup", 32'(deploy_pickup), 32'(e_dp));
    chk("pending_tree", 32'(pending_tree), 32'(m_pend[0]));
    chk("pending_bird", 32'(pending_bird), 32'(m_pend[1]));
    chk("idle", 32'(idle), 32'(m_idle));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One frame of 4 cycles; returns the deploys seen right after the startOfFrame edge.
  task automatic frame(output logic [15:0] dt, output logic [3:0] db, output logic dp);
    startOfFrame = 1'b1;
    cyc();
    dt = deploy_tree; db = deploy_bird; dp = deploy_pickup;
    startOfFrame = 1'b0;
    repeat (3) cyc();
    if (auto_alive) begin
      tree_alive = tree_alive | dt;
      bird_alive = bird_alive | db;
      pickup_alive = pickup_alive | dp;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  logic [15:0] dt;
  logic [3:0]  db;
  logic        dp;
  int          rr_t[5];
  int          rr_b[5];
  int          rr_p[5];

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; flush = 1'b0;
    add_tree_valid = 1'b0; add_tree_cnt = '0; add_bird_valid = 1'b0; add_bird_cnt = '0;
    req_pickup = 1'b0; tree_alive = '0; bird_alive = '0; pickup_alive = 1'b0;
    model_clear();
    #1;
    chk("rst_deploy_tree", 32'(deploy_tree), 32'h0);
    chk("rst_pending_tree", 32'(pending_tree), 32'h0);
    chk("rst_pending_bird", 32'(pending_bird), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    @(posedge clk); #1;
    resetN = 1'b1;

    // Tree spacing: three trees on frames 0, 8, 16; objects come alive after deploy.
    auto_alive = 1;
    add_tree_valid = 1'b1; add_tree_cnt = 4'd3;
    cyc();
    add_tree_valid = 1'b0;
    chk("t1_pend_init", 32'(pending_tree), 32'd3);
    for (int f = 0; f < 24; f++) begin
      frame(dt, db, dp);
      if (f == 0)  begin chk("t1_f0_dep", 32'(dt), 32'h0001); chk("t1_f0_pend", 32'(pending_tree), 32'd2); end
      if (f == 1)  chk("t1_f1_nodep", 32'(dt), 32'h0000);
      if (f == 8)  begin chk("t1_f8_dep", 32'(dt), 32'h0002); chk("t1_f8_pend", 32'(pending_tree), 32'd1); end
      if (f == 16) begin chk("t1_f16_dep", 32'(dt), 32'h0004); chk("t1_f16_pend", 32'(pending_tree), 32'd0); end
    end
    chk("t1_idle_end", 32'(idle), 32'h1);

    // Round-robin across classes.
    tree_alive = '0; bird_alive = '0; pickup_alive = 1'b0;
    do_flush();
    rr_t = '{1, 0, 0, 2, 0};
    rr_b = '{0, 1, 0, 0, 2};
    rr_p = '{0, 0, 1, 0, 0};
    add_tree_valid = 1'b1; add_tree_cnt = 4'd2; add_bird_valid = 1'b1; add_bird_cnt = 3'd2; req_pickup = 1'b1;
    cyc();
    add_tree_valid = 1'b0; add_bird_valid = 1'b0; req_pickup = 1'b0;
    for (int f = 0; f < 33; f++) begin
      frame(dt, db, dp);
      if (f % 8 == 0) begin
        chk("t2_tree", 32'(dt), 32'(rr_t[f / 8]));
        chk("t2_bird", 32'(db), 32'(rr_b[f / 8]));
        chk("t2_pick", 32'(dp), 32'(rr_p[f / 8]));
      end
    end

    // No free bird slot: nothing deploys until a slot frees up.
    auto_alive = 0;
    tree_alive = '0; bird_alive = 4'hF; pickup_alive = 1'b0;
    do_flush();
    add_bird_valid = 1'b1; add_bird_cnt = 3'd2;
    cyc();
    add_bird_valid = 1'b0;
    for (int f = 0; f < 3; f++) begin
      frame(dt, db, dp);
      chk("t3_blocked", 32'(db), 32'h0);
    end
    chk("t3_pend", 32'(pending_bird), 32'd2);
    bird_alive[2] = 1'b0;
    frame(dt, db, dp);
    chk("t3_unblock", 32'(db), 32'h4);

    // Reservation timeout: slot0 never comes alive and is reused once its reservation expires.
    bird_alive = '0;
    do_flush();
    add_tree_valid = 1'b1; add_tree_cnt = 4'd2;
    cyc();
    add_tree_valid = 1'b0;
    for (int f = 0; f < 9; f++) begin
      frame(dt, db, dp);
      if (f == 0) chk("t4_first", 32'(dt), 32'h0001);
      if (f == 8) chk("t4_reuse", 32'(dt), 32'h0001);
    end

    // Saturation, then add and grant on the same edge.
    do_flush();
    add_tree_valid = 1'b1; add_tree_cnt = 4'd15;
    repeat (3) cyc();
    chk("t5_sat", 32'(pending_tree), 32'd31);
    add_tree_cnt = 4'd4; startOfFrame = 1'b1;
    cyc();
    add_tree_valid = 1'b0; startOfFrame = 1'b0;
    chk("t5_add_grant_pend", 32'(pending_tree), 32'd30);
    chk("t5_add_grant_dep", 32'(deploy_tree), 32'h0001);

    // Flush on a frame pulse wins over the grant.
    do_flush();
    add_tree_valid = 1'b1; add_tree_cnt = 4'd5;
    cyc();
    add_tree_valid = 1'b0;
    flush = 1'b1; startOfFrame = 1'b1;
    cyc();
    flush = 1'b0; startOfFrame = 1'b0;
    chk("t6_nodep", 32'(deploy_tree), 32'h0);
    chk("t6_pend", 32'(pending_tree), 32'd0);
    chk("t6_idle", 32'(idle), 32'h1);
    add_tree_valid = 1'b1; add_tree_cnt = 4'd1;
    cyc();
    add_tree_valid = 1'b0;
    frame(dt, db, dp);
    chk("t6_regrant", 32'(dt), 32'h0001);

    // Asynchronous reset truncates a live deploy pulse.
    tree_alive = '0;
    do_flush();
    add_tree_valid = 1'b1; add_tree_cnt = 4'd2;
    cyc();
    add_tree_valid = 1'b0;
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    chk("t7_pulse", 32'(deploy_tree), 32'h0001);
    #2 resetN = 1'b0;
    #1;
    chk("t7_trunc", 32'(deploy_tree), 32'h0);
    chk("t7_pend", 32'(pending_tree), 32'd0);
    chk("t7_idle", 32'(idle), 32'h1);
    model_clear();
    @(posedge clk); #1;
    resetN = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      startOfFrame = (n % 4 == 0);
      flush = ($urandom_range(0, 199) == 0);
      add_tree_valid = ($urandom_range(0, 7) == 0);
      add_tree_cnt = 4'($urandom_range(0, 15));
      add_bird_valid = ($urandom_range(0, 7) == 0);
      add_bird_cnt = 3'($urandom_range(0, 7));
      req_pickup = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) tree_alive[$urandom_range(0, 15)] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bird_alive[$urandom_range(0, 3)] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) pickup_alive = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
